pool_sched: RTL

POOL_SCHED -- requirements
Module: pool_sched

---
 rtl/pool_sched_if.sv | 39 +++
 rtl/pool_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pool_sched_if.sv
// Pooling scheduler bus: start/abort/config from the controller, per-point command
// and status toward the pool unit. perf_cycles exists only with POOL_SCHED_PERF_EN.
interface pool_sched_if #(
   parameter int unsigned ADDR_W = 28
);
   logic              start;
   logic              abort;
   logic [5:0]        cfg_rows;
   logic [5:0]        cfg_cols;
   logic [ADDR_W-1:0] cfg_base;
   logic              pool_ack;
   logic              pool_go;
   logic              pt_en;
   logic [5:0]        ptr;
   logic [5:0]        ptc;
   logic [ADDR_W-1:0] pt_addr;
   logic              busy;
   logic              done;
   logic [12:0]       pts_done;
`ifdef POOL_SCHED_PERF_EN
   logic [31:0]       perf_cycles;
`endif

   modport slave (
`ifdef POOL_SCHED_PERF_EN
      output perf_cycles,
`endif
      input  start, abort, cfg_rows, cfg_cols, cfg_base, pool_ack,
      output pool_go, pt_en, ptr, ptc, pt_addr, busy, done, pts_done
   );

   modport master (
`ifdef POOL_SCHED_PERF_EN
      input  perf_cycles,
`endif
      output start, abort, cfg_rows, cfg_cols, cfg_base, pool_ack,
      input  pool_go, pt_en, ptr, ptc, pt_addr, busy, done, pts_done
   );
endinterface

// File: rtl/pool_sched.sv
// Walks an output feature map point by point, issuing one pool_go per (row, col)
// and waiting for pool_ack. Optional busy-cycle counter under POOL_SCHED_PERF_EN.
module pool_sched #(
   parameter int unsigned ADDR_W    = 28,
   parameter int unsigned CH_STRIDE = 64
) (
   input  logic        clk,
   input  logic        rst,
   pool_sched_if.slave bus
);
   localparam int unsigned PT_W   = 6;
   localparam int unsigned CNT_W  = 13;
   localparam int unsigned PROD_W = ADDR_W + 32;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADV, DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PT_W-1:0]   r_rows;
   logic [PT_W-1:0]   r_cols;
   logic [PT_W-1:0]   r_ptr;
   logic [PT_W-1:0]   r_ptc;
   logic [PT_W-1:0]   w_rows_nxt;
   logic [PT_W-1:0]   w_cols_nxt;
   logic [PT_W-1:0]   w_ptr_nxt;
   logic [PT_W-1:0]   w_ptc_nxt;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] w_base_nxt;
   logic [ADDR_W-1:0] r_pt_addr;
   logic [ADDR_W-1:0] w_pt_addr_nxt;
   logic [CNT_W-1:0]  r_pts_done;
   logic [CNT_W-1:0]  w_pts_nxt;
   logic              r_pool_go;
   logic              r_busy;
   logic              r_done;
   logic              w_start_acc;

   // abort beats start even in IDLE
   assign w_start_acc = (r_state == IDLE) && bus.start && !bus.abort;

   always_comb begin
      w_state_nxt = r_state;
      w_rows_nxt  = r_rows;
      w_cols_nxt  = r_cols;
      w_base_nxt  = r_base;
      w_ptr_nxt   = r_ptr;
      w_ptc_nxt   = r_ptc;
      w_pts_nxt   = r_pts_done;
      if ((r_state != IDLE) && bus.abort) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start_acc) begin
                  w_rows_nxt  = bus.cfg_rows;
                  w_cols_nxt  = bus.cfg_cols;
                  w_base_nxt  = bus.cfg_base;
                  w_ptr_nxt   = '0;
                  w_ptc_nxt   = '0;
                  w_pts_nxt   = '0;
                  w_state_nxt = ISSUE;
               end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
               if (bus.pool_ack) begin
                  w_pts_nxt   = r_pts_done + CNT_W'(1);
                  w_state_nxt = ADV;
               end
            end
            ADV: begin
               if (r_ptc < r_cols) begin
                  w_ptc_nxt   = r_ptc + PT_W'(1);
                  w_state_nxt = ISSUE;
               end else if (r_ptr < r_rows) begin
                  w_ptc_nxt   = '0;
                  w_ptr_nxt   = r_ptr + PT_W'(1);
                  w_state_nxt = ISSUE;
               end else begin
                  w_state_nxt = DONE;
               end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // {ptr, ptc} is ptr*64 + ptc; product kept wide, sum wraps at ADDR_W
   assign w_pt_addr_nxt = w_base_nxt
                        + ADDR_W'(PROD_W'({w_ptr_nxt, w_ptc_nxt}) * PROD_W'(CH_STRIDE));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_rows     <= '0;
         r_cols     <= '0;
         r_base     <= '0;
         r_ptr      <= '0;
         r_ptc      <= '0;
         r_pt_addr  <= '0;
         r_pts_done <= '0;
         r_pool_go  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rows     <= w_rows_nxt;
         r_cols     <= w_cols_nxt;
         r_base     <= w_base_nxt;
         r_ptr      <= w_ptr_nxt;
         r_ptc      <= w_ptc_nxt;
         r_pt_addr  <= w_pt_addr_nxt;
         r_pts_done <= w_pts_nxt;
         r_pool_go  <= (w_state_nxt == ISSUE);
         r_busy     <= (w_state_nxt != IDLE);
         r_done     <= (w_state_nxt == DONE);
      end
   end

   assign bus.pool_go  = r_pool_go;
   assign bus.pt_en    = r_pool_go;
   assign bus.ptr      = r_ptr;
   assign bus.ptc      = r_ptc;
   assign bus.pt_addr  = r_pt_addr;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.pts_done = r_pts_done;

`ifdef POOL_SCHED_PERF_EN
   logic [31:0] r_perf_cycles;

   // counts cycles spent busy in the current/last pass, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_cycles <= '0;
      end else if (w_start_acc) begin
         r_perf_cycles <= '0;
      end else if (r_busy && (r_perf_cycles != 32'hFFFF_FFFF)) begin
         r_perf_cycles <= r_perf_cycles + 32'd1;
      end
   end

   assign bus.perf_cycles = r_perf_cycles;
`endif
endmodule
